// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Runs one shift-add or restoring-divide step per cycle, then a single sign-fixup cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] move_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0]     m_q, m_d;         // multiplicand (mult) or divisor (div) magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // {product_hi, product_lo} or {remainder, quotient}
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d, dbz_q, dbz_d, busy_q, busy_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, rem_shift, trial;
  logic [2*WIDTH-1:0]   mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  assign a_mag = (op[0] && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign b_mag = (op[0] && operand_b[WIDTH-1]) ? -operand_b : operand_b;

  // Shift-add: add multiplicand into the upper half when the current multiplier bit is set.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : '0)};
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: quotient bits shift in at the bottom as dividend bits shift out the top.
  assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, m_q};
  assign div_step  = trial[WIDTH] ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0],     acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    m_d      = m_q;
    acc_d    = acc_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          sign_a_d = op[0] & operand_a[WIDTH-1];
          sign_b_d = op[0] & operand_b[WIDTH-1];
          m_d      = op[1] ? b_mag : a_mag;
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          count_d  = '0;
          state_d  = RUN;
        end else begin
          if (hi_we) hi_d = move_data;
          if (lo_we) lo_d = move_data;
        end
      end
      RUN: begin
        acc_d   = op_q[1] ? div_step : mul_step;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        dbz_d   = op_q[1] && (m_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random operations
// compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0, operand_b = '0, move_data = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic        exp_dbz = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_we(hi_we), .lo_we(lo_we), .move_data(move_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural result of one operation, from plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    z  = o[1] && (b == 32'd0);
    h  = '0;
    l  = '0;
    case (o)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'b10: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin h = a % b; l = a / b; end
      end
      default: begin
        if (b == 0) begin
          // |a|/0 gives all-ones quotient and remainder |a|, then sign fixup by sign of a.
          h = a;
          l = a[31] ? 32'd1 : 32'hFFFF_FFFF;
        end else begin
          q = sa / sb;
          r = sa % sb;
          h = r[31:0];
          l = q[31:0];
        end
      end
    endcase
  endfunction

  // Issue one operation; optionally pair start with MTLO, and poke start/hi_we at cycle inject_at.
  task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int inject_at, input bit with_lo_we);
    logic [31:0] eh, el;
    logic        ez;
    int          n;
    bit          busy_ok;
    model(o, a, b, eh, el, ez);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    lo_we = with_lo_we; move_data = $urandom;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    operand_a = $urandom; operand_b = $urandom; op = 2'($urandom);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (n == inject_at) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; move_data = $urandom;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check({tag, " latency"}, 64'(n), 64'd33);
    check({tag, " busy_during"}, 64'(busy_ok), 64'd1);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    check({tag, " dbz"}, 64'(div_by_zero), 64'(ez));
    exp_hi = eh; exp_lo = el; exp_dbz = ez;
    @(negedge clk);
    check({tag, " done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          saw_done;

    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset dbz", 64'(div_by_zero), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    check("multu_max hi_const", 64'(hi), 64'hFFFF_FFFE);
    issue("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005, -1, 1'b0);
    check("mult_neg lo_const", 64'(lo), 64'hFFFF_FFF1);
    issue("div_neg", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b0);
    check("div_neg lo_const", 64'(lo), 64'hFFFF_FFFD);
    issue("divu_zero", 2'b10, 32'h0000_0064, 32'h0, -1, 1'b0);
    check("divu_zero dbz_const", 64'(div_by_zero), 64'd1);
    issue("divu_100_7", 2'b10, 32'd100, 32'd7, -1, 1'b0);
    check("divu_100_7 lo_const", 64'(lo), 64'h0000_000E);
    issue("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    check("div_ovf lo_const", 64'(lo), 64'h8000_0000);
    issue("div_zero_neg", 2'b11, 32'hFFFF_FF00, 32'h0, -1, 1'b0);

    // MTHI while idle: lo keeps its value and no done pulse.
    @(negedge clk);
    hi_we = 1'b1; move_data = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    exp_hi = 32'h1234_5678;
    check("mthi hi", 64'(hi), 64'(exp_hi));
    check("mthi lo", 64'(lo), 64'(exp_lo));
    check("mthi done", 64'(done), 64'd0);
    check("mthi dbz_held", 64'(div_by_zero), 64'(exp_dbz));
    @(negedge clk);
    lo_we = 1'b1; move_data = 32'hCAFE_F00D;
    @(negedge clk);
    lo_we = 1'b0;
    exp_lo = 32'hCAFE_F00D;
    check("mtlo lo", 64'(lo), 64'(exp_lo));
    check("mtlo hi", 64'(hi), 64'(exp_hi));

    issue("start_with_mtlo", 2'b00, 32'd7, 32'd9, -1, 1'b1);
    issue("inject_mid", 2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 10, 1'b0);

    // Asynchronous reset in the middle of a MULTU.
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'hFFFF_FFFF; operand_b = 32'h0000_0003;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", 64'(busy), 64'd0);
    check("arst hi", 64'(hi), 64'd0);
    check("arst lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("arst no_done", 64'(saw_done), 64'd0);
    check("arst hi_after", 64'(hi), 64'd0);
    check("arst dbz", 64'(div_by_zero), 64'd0);
    issue("after_reset", 2'b00, 32'h0001_0000, 32'h0001_0000, -1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      issue($sformatf("rand%0d_op%0d", k, ro), ro, ra, rb, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
